load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-stage load/store unit for the RV32I core. It sits directly downstream of the ALU and consumes the ALU result as the effective address for LOAD/STORE instructions. It runs a valid/ready bus transaction to data memory, with byte/halfword lane steering, load sign/zero extension, misalignment checking and a bus timeout. The pipeline control stalls on `busy` and writes back `load_result` on `done`.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1023: maximum cycles `mem_valid` is held without `mem_ready`; 0 disables the timeout.

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: request strobe; inputs below are sampled when `start`=1 in IDLE.
- `instruction` in 32: opcode [6:0] and funct3 [14:12] select LOAD/STORE and size.
- `addr` in 32: effective address from the ALU (`rs1 + imm`).
- `store_data` in 32: rs2 value.
- `busy` out 1: transaction in progress.
- `done` out 1: one-cycle completion pulse.
- `error` out 1: valid with `done`; misaligned, illegal funct3 or timeout.
- `load_result` out 32: extended load data; valid with `done`, and held until the next `done`.
- `mem_valid` out 1: bus request.
- `mem_ready` in 1: bus accept/complete.
- `mem_we` out 1: 1 for a store.
- `mem_addr` out 32: word address, with [1:0] always 0.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_wstrb` out 4: byte enables; 0 for loads.
- `mem_rdata` in 32: read data, sampled on the `mem_ready` cycle.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - `start` with opcode LOAD (0000011) or STORE (0100011) latches the address, size, type and data.
  - Legal and aligned requests go to ACCESS. Illegal or misaligned requests go to RESP with `error`=1 and no bus activity.
  - `start` with any other opcode is ignored.
- Legal funct3 values:
  - Loads: LB=0, LH=1, LW=2, LBU=4, LHU=5.
  - Stores: SB=0, SH=1, SW=2.
  - Any other value is illegal.
- ACCESS:
  - `mem_valid`=1 and all `mem_*` outputs are stable.
  - On a cycle with `mem_ready`=1, `mem_rdata` is captured and the FSM goes to RESP.
  - When the timeout counter reaches `TIMEOUT_CYCLES`, the FSM goes to RESP with `error`=1.
- RESP: `done`=1 for exactly one cycle, then IDLE.
- Store lanes:
  - SB: `wstrb`=4'b0001<<addr[1:0], `wdata`={4{sd[7:0]}}.
  - SH: `wstrb`=4'b0011<<{addr[1],1'b0}, `wdata`={2{sd[15:0]}}.
  - SW: `wstrb`=4'b1111.
- Load extraction:
  - The byte or halfword is selected by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - `load_result` is 0 for stores and for error completions.
- `start` while not in IDLE is ignored, including in the RESP cycle.
- Reset (asynchronous, valid at any point mid-transaction):
  - FSM goes to IDLE.
  - `busy`, `done`, `error`, `mem_valid`, `mem_we`, `mem_wstrb` go to 0.
  - `mem_addr`, `mem_wdata`, `load_result` go to 0.
  - The timeout counter goes to 0.
  - An in-flight transaction is abandoned without completion.

## Timing
- `start` sampled at edge T → `mem_valid`=1 and `busy`=1 from T+1.
- `mem_ready` first high in the cycle ending at edge T+k (k≥1) → RESP in cycle T+k+1, where `done`=1, `load_result` is valid and `mem_valid`=0. Minimum load latency is 2 cycles, start to done.
- `busy`=1 from T+1 through the RESP cycle inclusive. A new `start` is accepted in the cycle after `done`.
- Error path (illegal or misaligned): `done`=`error`=1 at T+1, `busy`=1 for that cycle only, `mem_valid` never asserted.
- Timeout: `mem_valid` high for exactly `TIMEOUT_CYCLES` cycles, then `done`=`error`=1. The counter saturates and clears on leaving ACCESS.
- `mem_ready` arriving in the same cycle the counter expires counts as success (no error).
- `mem_ready` outside ACCESS is ignored.

## Configuration
- `LSU_MISALIGN_CHECK_EN` defined:
  - A halfword access with addr[0]=1 completes with `error`=1 and no bus access.
  - A word access with addr[1:0]≠0 completes with `error`=1 and no bus access.
- `LSU_MISALIGN_CHECK_EN` undefined:
  - No misalignment error is raised.
  - Halfword accesses use addr[1] only (addr[0] ignored).
  - Word accesses ignore addr[1:0].
  - The access proceeds normally.

## Test plan
- LB at addr 0x1003, `mem_rdata`=0x80FF_FFFF, ready immediate → `mem_addr`=0x1000, `done` at T+2, `load_result`=0xFFFF_FF80. Same access with LBU → `load_result`=0x0000_0080.
- SH at addr 0x2002, `store_data`=0x1234_ABCD, ready after 3 wait cycles → `mem_wstrb`=4'b1100, `mem_wdata`=0xABCD_ABCD, `mem_we`=1, `mem_valid` high 4 cycles, `done`=1 with `error`=0.
- LW at addr 0x3001: with `LSU_MISALIGN_CHECK_EN`, `done`=`error`=1 at T+1 and no `mem_valid`; without it, `mem_addr`=0x3000 and a normal load.
- `TIMEOUT_CYCLES`=4, `mem_ready` held 0 → `mem_valid` high for exactly 4 cycles, then `done`=`error`=1 and `load_result`=0.
- `reset` asserted mid-ACCESS, asynchronously off-edge → `mem_valid` and `busy` drop immediately and no `done` is produced. A new LW after reset completes normally.
- `start` pulsed while busy, and `start` with opcode OP (0110011) in IDLE → both ignored: no bus activity and no `done`.

Source files
------------

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: valid/ready data bus, byte lane steering, load extension, timeout.
// Build option: define LSU_MISALIGN_CHECK_EN to fail misaligned halfword/word accesses.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] instruction,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] load_result,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] TmoLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e          state_q;
  logic            busy_q, done_q, error_q;
  logic [31:0]     load_result_q;
  logic            mem_valid_q, mem_we_q;
  logic [31:0]     mem_addr_q, mem_wdata_q;
  logic [3:0]      mem_wstrb_q;
  logic [2:0]      funct3_q;
  logic [1:0]      off_q;
  logic            store_q;
  logic [CntW-1:0] tmo_cnt_q;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_load, is_store, funct3_ok, misaligned, req_err;
  logic [3:0]  req_wstrb;
  logic [31:0] req_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic        tmo_hit;

  logic unused_instr;
  assign unused_instr = ^{instruction[31:15], instruction[11:7]};

  // Request decode and store lane steering, evaluated on the IDLE sampling cycle.
  always_comb begin
    opcode    = instruction[6:0];
    funct3    = instruction[14:12];
    is_load   = (opcode == OpLoad);
    is_store  = (opcode == OpStore);
    funct3_ok = 1'b0;
    if (is_load) begin
      funct3_ok = funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    end else if (is_store) begin
      funct3_ok = funct3 inside {3'd0, 3'd1, 3'd2};
    end
    misaligned = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
    case (funct3[1:0])
      2'b01:   misaligned = addr[0];
      2'b10:   misaligned = (addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
`endif
    req_err = !funct3_ok || misaligned;
    case (funct3[1:0])
      2'b00: begin
        req_wstrb = 4'b0001 << addr[1:0];
        req_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        req_wstrb = 4'b0011 << {addr[1], 1'b0};
        req_wdata = {2{store_data[15:0]}};
      end
      default: begin
        req_wstrb = 4'b1111;
        req_wdata = store_data;
      end
    endcase
  end

  // Load extraction from the captured byte offset and size.
  always_comb begin
    case (off_q)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'd0:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    ld_data = {{16{ld_half[15]}}, ld_half};
      3'd4:    ld_data = {24'd0, ld_byte};
      3'd5:    ld_data = {16'd0, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt_q == TmoLast);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      load_result_q <= '0;
      mem_valid_q   <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_wstrb_q   <= '0;
      funct3_q      <= '0;
      off_q         <= '0;
      store_q       <= 1'b0;
      tmo_cnt_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start && (is_load || is_store)) begin
            funct3_q <= funct3;
            off_q    <= addr[1:0];
            store_q  <= is_store;
            busy_q   <= 1'b1;
            if (req_err) begin
              state_q       <= StResp;
              done_q        <= 1'b1;
              error_q       <= 1'b1;
              load_result_q <= '0;
            end else begin
              state_q     <= StAccess;
              mem_valid_q <= 1'b1;
              mem_we_q    <= is_store;
              mem_addr_q  <= {addr[31:2], 2'b00};
              mem_wdata_q <= is_store ? req_wdata : 32'd0;
              mem_wstrb_q <= is_store ? req_wstrb : 4'd0;
              tmo_cnt_q   <= '0;
            end
          end
        end
        StAccess: begin
          // A ready in the expiry cycle wins over the timeout.
          if (mem_ready || tmo_hit) begin
            state_q       <= StResp;
            done_q        <= 1'b1;
            error_q       <= !mem_ready;
            load_result_q <= (mem_ready && !store_q) ? ld_data : 32'd0;
            mem_valid_q   <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_wstrb_q   <= '0;
            tmo_cnt_q     <= '0;
          end else if (tmo_cnt_q != TmoLast) begin
            tmo_cnt_q <= tmo_cnt_q + CntW'(1);
          end
        end
        StResp: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          error_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign load_result = load_result_q;
  assign mem_valid   = mem_valid_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_wstrb   = mem_wstrb_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, lanes, misalignment, timeout, reset, ignores.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] instruction = '0;
  logic [31:0] addr = '0;
  logic [31:0] store_data = '0;
  logic        busy, done, error;
  logic [31:0] load_result;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = '0;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .instruction (instruction),
    .addr        (addr),
    .store_data  (store_data),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .load_result (load_result),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_rdata   (mem_rdata)
  );

  function automatic logic [31:0] enc(input logic [2:0] f3, input logic [6:0] op);
    return {17'd0, f3, 5'd0, op};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] sd);
    start = 1'b1; instruction = ins; addr = a; store_data = sd;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #2;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0)
      $display("FAIL reset_ctl: busy/done/error=%b%b%b exp 000", busy, done, error);
    else passes++;
    checks++;
    if (mem_valid !== 1'b0 || mem_we !== 1'b0 || mem_wstrb !== 4'd0)
      $display("FAIL reset_bus: valid=%b we=%b wstrb=%b exp 0 0 0000", mem_valid, mem_we, mem_wstrb);
    else passes++;
    checks++;
    if (mem_addr !== 32'd0 || mem_wdata !== 32'd0 || load_result !== 32'd0)
      $display("FAIL reset_data: addr=%h wdata=%h result=%h exp 0", mem_addr, mem_wdata, load_result);
    else passes++;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_lb_lbu();
    mem_ready = 1'b1; mem_rdata = 32'h80FF_FFFF;
    do_start(enc(3'd0, 7'b0000011), 32'h0000_1003, 32'd0);
    checks++;
    if (mem_valid !== 1'b1 || busy !== 1'b1 || mem_addr !== 32'h0000_1000 || done !== 1'b0)
      $display("FAIL lb_access: valid=%b busy=%b addr=%h done=%b exp 1 1 00001000 0",
               mem_valid, busy, mem_addr, done);
    else passes++;
    checks++;
    if (mem_we !== 1'b0 || mem_wstrb !== 4'd0)
      $display("FAIL lb_nowrite: we=%b wstrb=%b exp 0 0000", mem_we, mem_wstrb);
    else passes++;
    tick();
    checks++;
    if (done !== 1'b1 || error !== 1'b0 || mem_valid !== 1'b0 || load_result !== 32'hFFFF_FF80)
      $display("FAIL lb_done: done=%b err=%b valid=%b result=%h exp 1 0 0 ffffff80",
               done, error, mem_valid, load_result);
    else passes++;
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || load_result !== 32'hFFFF_FF80)
      $display("FAIL lb_hold: done=%b busy=%b result=%h exp 0 0 ffffff80", done, busy, load_result);
    else passes++;
    do_start(enc(3'd4, 7'b0000011), 32'h0000_1003, 32'd0);
    tick();
    checks++;
    if (done !== 1'b1 || load_result !== 32'h0000_0080)
      $display("FAIL lbu_done: done=%b result=%h exp 1 00000080", done, load_result);
    else passes++;
    tick();
    mem_ready = 1'b0;
  endtask

  task automatic test_store_sh();
    int n = 0;
    mem_ready = 1'b0;
    do_start(enc(3'd1, 7'b0100011), 32'h0000_2002, 32'h1234_ABCD);
    checks++;
    if (mem_we !== 1'b1 || mem_wstrb !== 4'b1100 || mem_wdata !== 32'hABCD_ABCD ||
        mem_addr !== 32'h0000_2000)
      $display("FAIL sh_bus: we=%b wstrb=%b wdata=%h addr=%h exp 1 1100 abcdabcd 00002000",
               mem_we, mem_wstrb, mem_wdata, mem_addr);
    else passes++;
    for (int i = 0; i < 3; i++) begin
      if (mem_valid === 1'b1) n++;
      tick();
    end
    if (mem_valid === 1'b1) n++;
    // Ready lands in the same cycle the 4-cycle timeout expires: must still succeed.
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    checks++;
    if (n !== 4) $display("FAIL sh_valid_cycles: got %0d exp 4", n);
    else passes++;
    checks++;
    if (done !== 1'b1 || error !== 1'b0 || load_result !== 32'd0 || mem_valid !== 1'b0)
      $display("FAIL sh_done: done=%b err=%b result=%h valid=%b exp 1 0 0 0",
               done, error, load_result, mem_valid);
    else passes++;
    tick();
  endtask

  task automatic test_lanes();
    mem_ready = 1'b1;
    do_start(enc(3'd0, 7'b0100011), 32'h0000_5001, 32'h1234_56A5);
    checks++;
    if (mem_wstrb !== 4'b0010 || mem_wdata !== 32'hA5A5_A5A5 || mem_addr !== 32'h0000_5000)
      $display("FAIL sb_lane: wstrb=%b wdata=%h addr=%h exp 0010 a5a5a5a5 00005000",
               mem_wstrb, mem_wdata, mem_addr);
    else passes++;
    tick();
    tick();
    mem_rdata = 32'h8001_7FFF;
    do_start(enc(3'd1, 7'b0000011), 32'h0000_4002, 32'd0);
    tick();
    checks++;
    if (done !== 1'b1 || load_result !== 32'hFFFF_8001)
      $display("FAIL lh_ext: done=%b result=%h exp 1 ffff8001", done, load_result);
    else passes++;
    tick();
    do_start(enc(3'd5, 7'b0000011), 32'h0000_4002, 32'd0);
    tick();
    checks++;
    if (done !== 1'b1 || load_result !== 32'h0000_8001)
      $display("FAIL lhu_ext: done=%b result=%h exp 1 00008001", done, load_result);
    else passes++;
    tick();
    mem_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int n = 0;
    mem_ready = 1'b0;
    do_start(enc(3'd2, 7'b0000011), 32'h0000_6000, 32'd0);
    while (mem_valid === 1'b1 && n < 10) begin
      n++;
      tick();
    end
    checks++;
    if (n !== 4) $display("FAIL tmo_valid_cycles: got %0d exp 4", n);
    else passes++;
    checks++;
    if (done !== 1'b1 || error !== 1'b1 || load_result !== 32'd0)
      $display("FAIL tmo_done: done=%b err=%b result=%h exp 1 1 0", done, error, load_result);
    else passes++;
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL tmo_idle: done=%b busy=%b exp 0 0", done, busy);
    else passes++;
  endtask

  task automatic test_misalign();
    mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    do_start(enc(3'd2, 7'b0000011), 32'h0000_3001, 32'd0);
`ifdef LSU_MISALIGN_CHECK_EN
    checks++;
    if (done !== 1'b1 || error !== 1'b1 || mem_valid !== 1'b0 || busy !== 1'b1 ||
        load_result !== 32'd0)
      $display("FAIL lw_misalign: done=%b err=%b valid=%b busy=%b result=%h exp 1 1 0 1 0",
               done, error, mem_valid, busy, load_result);
    else passes++;
    tick();
`else
    checks++;
    if (mem_valid !== 1'b1 || mem_addr !== 32'h0000_3000)
      $display("FAIL lw_unaligned_bus: valid=%b addr=%h exp 1 00003000", mem_valid, mem_addr);
    else passes++;
    tick();
    checks++;
    if (done !== 1'b1 || error !== 1'b0 || load_result !== 32'hDEAD_BEEF)
      $display("FAIL lw_unaligned_done: done=%b err=%b result=%h exp 1 0 deadbeef",
               done, error, load_result);
    else passes++;
    tick();
`endif
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || mem_valid !== 1'b0)
      $display("FAIL lw_after: done=%b busy=%b valid=%b exp 0 0 0", done, busy, mem_valid);
    else passes++;
    mem_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic seen = 1'b0;
    mem_ready = 1'b0;
    do_start(enc(3'd2, 7'b0000011), 32'h0000_7000, 32'd0);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (mem_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL rst_async: valid=%b busy=%b exp 0 0", mem_valid, busy);
    else passes++;
    #2 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) $display("FAIL rst_no_done: done seen=%b exp 0", seen);
    else passes++;
    mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    do_start(enc(3'd2, 7'b0000011), 32'h0000_7004, 32'd0);
    tick();
    checks++;
    if (done !== 1'b1 || error !== 1'b0 || load_result !== 32'h1234_5678)
      $display("FAIL rst_relaunch: done=%b err=%b result=%h exp 1 0 12345678",
               done, error, load_result);
    else passes++;
    tick();
    mem_ready = 1'b0;
  endtask

  task automatic test_ignored();
    mem_ready = 1'b0; mem_rdata = 32'h0BAD_F00D;
    do_start(enc(3'd2, 7'b0000011), 32'h0000_8000, 32'd0);
    do_start(enc(3'd2, 7'b0100011), 32'h0000_9000, 32'hFFFF_FFFF);
    checks++;
    if (mem_addr !== 32'h0000_8000 || mem_we !== 1'b0 || mem_valid !== 1'b1)
      $display("FAIL busy_start: addr=%h we=%b valid=%b exp 00008000 0 1",
               mem_addr, mem_we, mem_valid);
    else passes++;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    checks++;
    if (done !== 1'b1 || load_result !== 32'h0BAD_F00D)
      $display("FAIL busy_done: done=%b result=%h exp 1 0badf00d", done, load_result);
    else passes++;
    // Start offered in the RESP cycle must be dropped.
    do_start(enc(3'd2, 7'b0000011), 32'h0000_A000, 32'd0);
    checks++;
    if (mem_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL resp_start: valid=%b busy=%b done=%b exp 0 0 0", mem_valid, busy, done);
    else passes++;
    do_start(enc(3'd0, 7'b0110011), 32'h0000_B000, 32'd0);
    checks++;
    if (mem_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL op_start: valid=%b busy=%b done=%b exp 0 0 0", mem_valid, busy, done);
    else passes++;
    tick();
    checks++;
    if (done !== 1'b0 || mem_valid !== 1'b0)
      $display("FAIL op_later: done=%b valid=%b exp 0 0", done, mem_valid);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_lb_lbu();
    test_store_sh();
    test_lanes();
    test_timeout();
    test_misalign();
    test_reset_mid();
    test_ignored();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
